// File: rtl/ascii_uart_tx.sv
// ascii_uart_tx
//   Buffers ASCII bytes from the transform stage in a small FIFO and sends them
//   as UART 8N1 frames on a registered, idle-high tx line. A popped 0x00 is
//   sent as a CR frame followed by an LF frame; the LF comes from a pending
//   flag so it never takes a FIFO slot.
//
// Ports
//   clk         single clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   din         ASCII byte to enqueue
//   din_valid   din is valid this cycle
//   din_ready   FIFO can accept a byte this cycle (low while in reset)
//   tx          serial line, idle high
//   busy        frame on tx, FIFO non-empty or LF pending
//   fifo_count  current FIFO occupancy, 0..FIFO_DEPTH
//
// Serializer states
//   state | meaning
//   IDLE  | line high; load pending LF, else pop next FIFO byte
//   START | start bit (low), CLKS_PER_BIT cycles
//   DATA  | 8 data bits LSB first, CLKS_PER_BIT cycles each
//   STOP  | stop bit (high), CLKS_PER_BIT cycles
module ascii_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       din_ready,
    output logic       tx,
    output logic       busy,
    output logic [4:0] fifo_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [4:0]       DEPTH_C    = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [4:0]       count_q, count_d;
    logic             push, pop;

    // Ready comes only from the registered count, so a pop in the same cycle
    // never lets a push into a full FIFO.
    assign din_ready  = rst_n & (count_q < DEPTH_C);
    assign push       = din_valid & din_ready;
    assign fifo_count = count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Serializer
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             lf_q, lf_d;
    logic             tx_q, tx_d;
    logic             frame_q;
    logic [7:0]       head;

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        lf_d      = lf_q;
        pop       = 1'b0;
        tx_d      = 1'b1;

        case (state_q)
            IDLE: begin
                if (lf_q) begin
                    shreg_d = 8'h0A;
                    lf_d    = 1'b0;
                    cnt_d   = BIT_RELOAD;
                    state_d = START;
                end else if (count_q != 5'd0) begin
                    pop = 1'b1;
                    if (head == 8'h00) begin
                        shreg_d = 8'h0D;
                        lf_d    = 1'b1;
                    end else begin
                        shreg_d = head;
                    end
                    cnt_d   = BIT_RELOAD;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    cnt_d     = BIT_RELOAD;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = BIT_RELOAD;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // The line follows the current state one cycle later, so every
        // state's full duration appears on tx unchanged.
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_q[bit_idx_q];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            lf_q      <= 1'b0;
            tx_q      <= 1'b1;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            lf_q      <= lf_d;
            tx_q      <= tx_d;
            frame_q   <= (state_q != IDLE);
        end
    end

    assign tx = tx_q;

    // frame_q covers the last stop cycle still on the line after the FSM has
    // already returned to IDLE.
    assign busy = (state_q != IDLE) | frame_q | (count_q != 5'd0) | lf_q;

endmodule
